fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Small circular FIFO between the instruction fetch stage and decode. Each
// entry holds the pc of an instruction and its 32-bit instruction word.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When defined, an entry presented while the queue is empty goes straight
//   to the outputs in the same cycle. If decode takes it in that cycle, it is
//   never written into the queue.
//   When undefined, there is no combinational path from in_* to out_*. An
//   entry pushed at one edge appears on the outputs in the following cycle.
//
// Parameters:
//   DEPTH      number of (pc, inst) entries; power of two, at least 2
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   nrst       synchronous active-low reset
//   flush      fetch redirect; throws away every stored entry
//   in_valid   fetch stage presents an entry
//   in_pc      pc of the presented instruction
//   in_inst    presented instruction word
//   in_ready   queue accepts an entry this cycle
//   out_valid  head entry is available to decode
//   out_pc     pc of the head entry (0 when out_valid is low)
//   out_inst   instruction of the head entry (0 when out_valid is low)
//   out_ready  decode consumes the head entry this cycle
//   count      number of stored entries
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

    // Storage is deliberately left out of reset; only pointers and count
    // say which slots hold live entries.
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic          empty;
    logic          full;
    logic          stored_valid;
    logic          bypass_hit;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_FULL);

    // in_ready looks only at the registered count, so a pop in the same
    // cycle never opens a slot for a push. While in reset the queue is
    // treated as empty and therefore ready.
    assign in_ready = !nrst || !full;

    assign stored_valid = nrst && !empty;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the presented entry directly. A flush in the same
    // cycle kills the forward, since the entry belongs to the old path.
    assign bypass_hit  = nrst && empty && in_valid && !flush;
    assign bypass_take = bypass_hit && out_ready;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign out_valid = stored_valid || bypass_hit;

    always_comb begin
        out_pc   = 32'h0;
        out_inst = 32'h0;
        if (stored_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end else if (bypass_hit) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // A forwarded entry that decode takes immediately is neither written
    // nor popped from storage; the queue stays empty.
    assign wr_en = nrst && push && !flush && !bypass_take;
    assign rd_en = nrst && pop  && !flush && !bypass_take;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Push blocked when full and pop blocked when empty, so the
            // counter can neither overflow nor underflow.
            if (wr_en && !rd_en) begin
                cnt <= cnt + CNT_ONE;
            end else if (rd_en && !wr_en) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        nrst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a plain queue of {pc, inst} in arrival order.
    logic [63:0] model [$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, check outputs before the edge against
    // the model, then advance the model by the queue rules.
    task automatic cycle(input logic nr, input logic fl, input logic iv,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy);
        logic        ev, er, byp;
        logic [31:0] epc, einst;
        int          n;
        nrst = nr; flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
        @(negedge clk);
        n   = model.size();
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = nr && (n == 0) && iv && !fl;
`endif
        ev = nr && ((n != 0) || byp);
        er = !nr || (n != DEPTH);
        epc = 32'h0; einst = 32'h0;
        if (nr && n != 0) begin
            epc   = model[0][63:32];
            einst = model[0][31:0];
        end else if (byp) begin
            epc   = pc;
            einst = inst;
        end
        check_val("out_valid", 32'(out_valid), 32'(ev));
        check_val("in_ready",  32'(in_ready),  32'(er));
        check_val("count",     32'(count),     32'(n));
        check_val("out_pc",    out_pc,   epc);
        check_val("out_inst",  out_inst, einst);
        if (!nr || fl) begin
            model.delete();
        end else if (!(byp && ordy)) begin
            if (ev && ordy) void'(model.pop_front());
            if (iv && er)   model.push_back({pc, inst});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        model.delete();

        // Outputs while in reset, with an entry presented.
        cycle(1'b0, 1'b0, 1'b1, 32'h100, 32'h13, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Streaming pcs 0,4,8 with decode always ready.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i*4), 32'h1000 + 32'(i), 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Fill with decode stalled; fifth entry held until space frees.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i*4), 32'h2000 + 32'(i), 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'h2004, 1'b0);
        // Full with push and pop together: pop happens, push is blocked.
        cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'h2004, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'h2004, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Three stored, then flush while presenting pc 0x40.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h20 + 32'(i*4), 32'h3000 + 32'(i), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h40, 32'h3040, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Continuous push and pop across pointer wraps.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 32'h80 + 32'(i*4), 32'h4000 + 32'(i), 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'hC0 + 32'(i*4), 32'h5000 + 32'(i), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hD0, 32'h50D0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1),
                  $urandom & 32'hFFFF_FFFC,
                  $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
